// File: rtl/irq_mode_ctrl.sv
// Interrupt mode sequencer: edge-latches requests, enters one handler at an
// instruction boundary, drives mode/flush/redirect. Optional IRQ_SW_TRAP_EN adds a software trap input.

module irq_line (
    input  logic clk,
    input  logic rst_n,
    input  logic irq,
    input  logic clr,
    output logic pending
);
    logic irq_q;

    // A fresh edge on the same clock as the clear must not be lost, so set wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq_q   <= 1'b0;
            pending <= 1'b0;
        end else begin
            irq_q <= irq;
            if (irq && !irq_q)
                pending <= 1'b1;
            else if (clr)
                pending <= 1'b0;
        end
    end
endmodule

module irq_mode_ctrl #(
    parameter int              NUM_IRQ    = 4,
    parameter int              PC_W       = 16,
    parameter logic [PC_W-1:0] VEC_BASE   = 16'h0100,
    parameter logic [PC_W-1:0] VEC_STRIDE = 16'h0010
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic               instr_boundary,
    input  logic [PC_W-1:0]    pc_in,
    input  logic               iret,
`ifdef IRQ_SW_TRAP_EN
    input  logic               trap,
`endif
    output logic [1:0]         mode,
    output logic               flush,
    output logic               pc_load,
    output logic [PC_W-1:0]    pc_target,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [2:0]         irq_id,
    output logic [PC_W-1:0]    epc
);
    localparam logic [2:0] ST_RST     = 3'd0;
    localparam logic [2:0] ST_USER    = 3'd1;
    localparam logic [2:0] ST_ENTER   = 3'd2;
    localparam logic [2:0] ST_HANDLER = 3'd3;
    localparam logic [2:0] ST_EXIT    = 3'd4;

    // One extra id bit so a trap id of NUM_IRQ=8 never aliases line 0 internally.
    localparam int ID_W = 4;

    logic [2:0]         state, state_nxt;
    logic [ID_W-1:0]    id_q;
    logic [PC_W-1:0]    epc_q;
    logic [NUM_IRQ-1:0] pending;
    logic [NUM_IRQ-1:0] eligible;
    logic [NUM_IRQ-1:0] clr;
    logic [ID_W-1:0]    sel_id;
    logic               take_irq;
    logic               take_trap;
    logic               enter;

    for (genvar i = 0; i < NUM_IRQ; i++) begin : g_line
        irq_line u_line (
            .clk     (clk),
            .rst_n   (rst_n),
            .irq     (irq[i]),
            .clr     (clr[i]),
            .pending (pending[i])
        );
    end

    // Lowest enabled pending line wins.
    always_comb begin
        eligible = pending & irq_en;
        sel_id   = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (eligible[i]) sel_id = ID_W'(i);
    end

`ifdef IRQ_SW_TRAP_EN
    assign take_trap = (state == ST_USER) && trap;
`else
    assign take_trap = 1'b0;
`endif
    assign take_irq = (state == ST_USER) && instr_boundary && (|eligible);
    assign enter    = take_trap || take_irq;

    // A trap pre-empts line selection and leaves every line pending.
    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++)
            clr[i] = take_irq && !take_trap && (sel_id == ID_W'(i));
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_RST:     state_nxt = ST_USER;
            ST_USER:    if (enter) state_nxt = ST_ENTER;
            ST_ENTER:   state_nxt = ST_HANDLER;
            ST_HANDLER: if (iret) state_nxt = ST_EXIT;
            ST_EXIT:    state_nxt = ST_USER;
            default:    state_nxt = ST_RST;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_RST;
            id_q  <= '0;
            epc_q <= '0;
        end else begin
            state <= state_nxt;
            if (enter) begin
                id_q  <= take_trap ? ID_W'(NUM_IRQ) : sel_id;
                epc_q <= pc_in;
            end
        end
    end

    always_comb begin
        mode = 2'b00;
        case (state)
            ST_USER, ST_ENTER:   mode = 2'b01;
            ST_HANDLER, ST_EXIT: mode = 2'b10;
            default:             mode = 2'b00;
        endcase
    end

    assign flush   = (state == ST_ENTER) || (state == ST_EXIT);
    assign pc_load = flush;

    always_comb begin
        pc_target = '0;
        if (state == ST_ENTER)
            pc_target = VEC_BASE + PC_W'(id_q) * VEC_STRIDE;
        else if (state == ST_EXIT)
            pc_target = epc_q;
    end

    // Trap id never matches a line index, so its acknowledge stays zero.
    always_comb begin
        for (int i = 0; i < NUM_IRQ; i++)
            irq_ack[i] = (state == ST_ENTER) && (id_q == ID_W'(i));
    end

    assign irq_id = id_q[2:0];
    assign epc    = epc_q;
endmodule

// File: tb/tb_irq_mode_ctrl.sv
// Directed bench for irq_mode_ctrl (default build, no software trap).

module tb_irq_mode_ctrl;
    logic        clk;
    logic        rst_n;
    logic [3:0]  irq;
    logic [3:0]  irq_en;
    logic        instr_boundary;
    logic [15:0] pc_in;
    logic        iret;
    logic [1:0]  mode;
    logic        flush;
    logic        pc_load;
    logic [15:0] pc_target;
    logic [3:0]  irq_ack;
    logic [2:0]  irq_id;
    logic [15:0] epc;

    int checks = 0;
    int errors = 0;

    irq_mode_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .irq            (irq),
        .irq_en         (irq_en),
        .instr_boundary (instr_boundary),
        .pc_in          (pc_in),
        .iret           (iret),
        .mode           (mode),
        .flush          (flush),
        .pc_load        (pc_load),
        .pc_target      (pc_target),
        .irq_ack        (irq_ack),
        .irq_id         (irq_id),
        .epc            (epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst_n = 1'b0; irq = '0; iret = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL rst_mode: got %b exp 00", mode); end
        checks++; if ({flush, pc_load} !== 2'b00) begin errors++; $display("FAIL rst_strobes: got %b exp 00", {flush, pc_load}); end
        checks++; if (pc_target !== 16'h0) begin errors++; $display("FAIL rst_target: got %h exp 0000", pc_target); end
        checks++; if ({irq_ack, irq_id} !== 7'h0) begin errors++; $display("FAIL rst_ack_id: got %h exp 00", {irq_ack, irq_id}); end
        checks++; if (epc !== 16'h0) begin errors++; $display("FAIL rst_epc: got %h exp 0000", epc); end
        checks++; if (dut.pending !== 4'h0) begin errors++; $display("FAIL rst_pending: got %b exp 0000", dut.pending); end
        rst_n = 1'b1;
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL rel_mode0: got %b exp 00", mode); end
        @(negedge clk);
        checks++; if (mode !== 2'b01) begin errors++; $display("FAIL rel_mode1: got %b exp 01", mode); end
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL rel_pcload: got %b exp 0", pc_load); end
    endtask

    // Ends on a negedge with the core in the handler for line 2.
    task automatic test_single_entry();
        @(negedge clk); irq = '0; pc_in = 16'h0042; instr_boundary = 1'b1; irq_en = 4'hF;
        @(negedge clk); irq = 4'b0100;
        @(negedge clk);
        checks++; if (mode !== 2'b01) begin errors++; $display("FAIL se_wait_mode: got %b exp 01", mode); end
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL se_wait_pcload: got %b exp 0", pc_load); end
        @(negedge clk);
        checks++; if ({flush, pc_load} !== 2'b11) begin errors++; $display("FAIL se_strobes: got %b exp 11", {flush, pc_load}); end
        checks++; if (pc_target !== 16'h0120) begin errors++; $display("FAIL se_target: got %h exp 0120", pc_target); end
        checks++; if (irq_ack !== 4'b0100) begin errors++; $display("FAIL se_ack: got %b exp 0100", irq_ack); end
        checks++; if (mode !== 2'b01) begin errors++; $display("FAIL se_enter_mode: got %b exp 01", mode); end
        @(negedge clk);
        checks++; if (mode !== 2'b10) begin errors++; $display("FAIL se_hdl_mode: got %b exp 10", mode); end
        checks++; if (epc !== 16'h0042) begin errors++; $display("FAIL se_epc: got %h exp 0042", epc); end
        checks++; if (irq_id !== 3'd2) begin errors++; $display("FAIL se_id: got %0d exp 2", irq_id); end
        checks++; if ({pc_load, irq_ack} !== 5'h0) begin errors++; $display("FAIL se_hdl_strobes: got %b exp 00000", {pc_load, irq_ack}); end
    endtask

    task automatic test_iret(input logic [15:0] ret_pc);
        @(negedge clk); iret = 1'b1;
        @(negedge clk); iret = 1'b0;
        checks++; if ({flush, pc_load} !== 2'b11) begin errors++; $display("FAIL ex_strobes: got %b exp 11", {flush, pc_load}); end
        checks++; if (pc_target !== ret_pc) begin errors++; $display("FAIL ex_target: got %h exp %h", pc_target, ret_pc); end
        checks++; if ({mode, irq_ack} !== 6'b10_0000) begin errors++; $display("FAIL ex_mode_ack: got %b exp 100000", {mode, irq_ack}); end
        @(negedge clk);
        checks++; if (mode !== 2'b01) begin errors++; $display("FAIL ex_user_mode: got %b exp 01", mode); end
        checks++; if (pc_load !== 1'b0) begin errors++; $display("FAIL ex_user_pcload: got %b exp 0", pc_load); end
    endtask

    task automatic test_iret_in_user();
        @(negedge clk); iret = 1'b1;
        @(negedge clk); iret = 1'b0;
        checks++; if ({mode, pc_load} !== 3'b010) begin errors++; $display("FAIL iret_user: got %b exp 010", {mode, pc_load}); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk); irq = '0; pc_in = 16'h0050;
        @(negedge clk); irq = 4'b1010;
        @(negedge clk);
        @(negedge clk);
        checks++; if (pc_target !== 16'h0110) begin errors++; $display("FAIL bb_first_target: got %h exp 0110", pc_target); end
        checks++; if (irq_ack !== 4'b0010) begin errors++; $display("FAIL bb_first_ack: got %b exp 0010", irq_ack); end
        @(negedge clk);
        checks++; if (dut.pending !== 4'b1000) begin errors++; $display("FAIL bb_pending: got %b exp 1000", dut.pending); end
        iret = 1'b1;
        @(negedge clk); iret = 1'b0;
        checks++; if (pc_target !== 16'h0050) begin errors++; $display("FAIL bb_exit_target: got %h exp 0050", pc_target); end
        @(negedge clk);
        checks++; if ({mode, pc_load} !== 3'b010) begin errors++; $display("FAIL bb_user: got %b exp 010", {mode, pc_load}); end
        @(negedge clk);
        checks++; if ({flush, pc_load} !== 2'b11) begin errors++; $display("FAIL bb_second_strobes: got %b exp 11", {flush, pc_load}); end
        checks++; if (pc_target !== 16'h0130) begin errors++; $display("FAIL bb_second_target: got %h exp 0130", pc_target); end
        checks++; if (irq_ack !== 4'b1000) begin errors++; $display("FAIL bb_second_ack: got %b exp 1000", irq_ack); end
        @(negedge clk);
        checks++; if (irq_id !== 3'd3) begin errors++; $display("FAIL bb_second_id: got %0d exp 3", irq_id); end
        test_iret(16'h0050);
    endtask

    task automatic test_disabled_line();
        @(negedge clk); irq = '0; irq_en = 4'b1110;
        @(negedge clk); irq = 4'b0001;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++; if ({mode, pc_load} !== 3'b010) begin errors++; $display("FAIL dis_hold%0d: got %b exp 010", i, {mode, pc_load}); end
        end
        irq_en = 4'hF; instr_boundary = 1'b0;
        @(negedge clk);
        checks++; if ({mode, pc_load} !== 3'b010) begin errors++; $display("FAIL dis_no_boundary: got %b exp 010", {mode, pc_load}); end
        instr_boundary = 1'b1;
        @(negedge clk);
        checks++; if (pc_target !== 16'h0100) begin errors++; $display("FAIL dis_target: got %h exp 0100", pc_target); end
        checks++; if (irq_ack !== 4'b0001) begin errors++; $display("FAIL dis_ack: got %b exp 0001", irq_ack); end
        @(negedge clk);
        checks++; if ({mode, irq_id} !== 5'b10_000) begin errors++; $display("FAIL dis_hdl: got %b exp 10000", {mode, irq_id}); end
        test_iret(16'h0050);
    endtask

    task automatic test_reset_in_handler();
        test_single_entry();
        irq = 4'b1100;
        @(negedge clk);
        checks++; if (dut.pending !== 4'b1000) begin errors++; $display("FAIL rh_latched: got %b exp 1000", dut.pending); end
        checks++; if ({mode, pc_load} !== 3'b100) begin errors++; $display("FAIL rh_not_serviced: got %b exp 100", {mode, pc_load}); end
        rst_n = 1'b0;
        #1;
        checks++; if (mode !== 2'b00) begin errors++; $display("FAIL rh_mode: got %b exp 00", mode); end
        checks++; if (dut.pending !== 4'h0) begin errors++; $display("FAIL rh_pending: got %b exp 0000", dut.pending); end
        checks++; if ({pc_load, epc} !== 17'h0) begin errors++; $display("FAIL rh_pcload_epc: got %h exp 0", {pc_load, epc}); end
        test_reset();
        test_single_entry();
        test_iret(16'h0042);
    endtask

    initial begin
        rst_n = 1'b0; irq = '0; irq_en = 4'hF; instr_boundary = 1'b0;
        pc_in = '0; iret = 1'b0;
        test_reset();
        test_single_entry();
        test_iret(16'h0042);
        test_iret_in_user();
        test_back_to_back();
        test_disabled_line();
        test_reset_in_handler();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
